servive: RTL and testbench
==========================

SERVIVE -- requirements
Module: servive

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning i_clk cycles per UART bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter MSG_GAP, default 1000, meaning idle i_clk cycles before each message; legal range 1..2^24-1.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock, rising-edge active, 50 MHz nominal.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port q, output, 1 bit: registered heartbeat that toggles once per transmitted message.
REQ-006 SHALL have port uart_txd, output, 1 bit: registered UART transmit line, idle high.

Function
REQ-007 SHALL transmit on uart_txd in 8N1 format: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-008 SHALL hold every bit, including start and stop, for exactly CLKS_PER_BIT cycles.
REQ-009 SHALL send one message as 4 bytes: ASCII uppercase hex of msg_cnt[7:4], ASCII hex of msg_cnt[3:0], 0x0D, 0x0A.
- Nibbles 0-9 map to 0x30-0x39; nibbles A-F map to 0x41-0x46.
REQ-010 SHALL keep msg_cnt as an internal 8-bit counter, reset to 0x00, incremented by 1 after the last stop bit of each message, wrapping 0xFF -> 0x00.
REQ-011 SHALL send the bytes of one message back-to-back: the next start bit begins on the cycle immediately after the previous stop bit ends.
REQ-012 SHALL implement the states GAP, START, DATA, STOP.
- GAP -> START after MSG_GAP cycles.
- START -> DATA after CLKS_PER_BIT cycles.
- DATA -> STOP after 8 bits.
- STOP -> START when more bytes remain in the message; STOP -> GAP after the 4th byte.
REQ-013 SHALL drive uart_txd high throughout GAP.
REQ-014 SHALL start the first message so that uart_txd falls at the MSG_GAP-th rising edge after the first edge at which i_rst is sampled low.
REQ-015 SHALL toggle q on the same edge at which the first start bit of each message is driven, so q is 1 during odd-numbered messages (1st, 3rd, ...).
REQ-016 SHALL take each message's byte values from msg_cnt latched at that message's first start bit, so message contents are stable for the whole message.
REQ-017 SHALL produce one complete message every MSG_GAP + 40*CLKS_PER_BIT cycles (18360 with default parameters).

Reset
REQ-018 SHALL, on any rising edge with i_rst = 1, set uart_txd = 1, q = 0, msg_cnt = 0x00, state = GAP, and clear all bit, byte and gap counters.
REQ-019 SHALL have reset override all activity, including mid-bit or mid-message, with outputs taking their reset values on that same edge.
REQ-020 SHALL, after reset is released, start again at the first message "00\r\n" following the REQ-014 timing.
REQ-021 SHALL hold uart_txd = 1 and q = 0 constant for as long as i_rst stays high.

Verification
REQ-022 SHALL pass: hold i_rst = 1 for 3 cycles -> uart_txd = 1 and q = 0 on every cycle.
REQ-023 SHALL pass, with defaults: release reset -> uart_txd falls and q rises 1000 cycles later; decoded bytes are 0x30, 0x30, 0x0D, 0x0A, each bit 434 cycles long.
REQ-024 SHALL pass: the second message decodes as 0x30, 0x31, 0x0D, 0x0A, and q falls at its first start bit.
REQ-025 SHALL pass, with CLKS_PER_BIT = 4 and MSG_GAP = 2: message 256 decodes as "FF\r\n" (0x46, 0x46, 0x0D, 0x0A) and message 257 decodes as "00\r\n".
REQ-026 SHALL pass: assert i_rst during the DATA state of byte 2 -> uart_txd = 1 and q = 0 on that edge; after release, the first message decodes as "00\r\n" with REQ-014 timing.
REQ-027 SHALL pass: with CLKS_PER_BIT = 4, the stop bit of byte 1 and the start bit of byte 2 are separated by no idle cycles.

Source files
------------

// File: rtl/servive.sv
`default_nettype none
// ==========================================================================
// servive: UART heartbeat; sends msg_cnt as two hex digits + CRLF, 8N1.
// Revision 1.0
// ==========================================================================
module servive #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MSG_GAP      = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic q,
  output logic uart_txd
);

  typedef enum logic [1:0] {
    GAP   = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [15:0] CPB_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [23:0] GAP_M1 = 24'(MSG_GAP - 1);

  state_t      state;
  logic [23:0] gap_cnt;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [1:0]  byte_idx;
  logic [7:0]  msg_cnt;
  logic [7:0]  msg_lat;
  logic [7:0]  cur_byte;
  logic [2:0]  nxt_bit;
  logic        bit_end;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // Message contents come from the copy taken at the first start bit.
  always_comb begin
    cur_byte = 8'h0A;
    case (byte_idx)
      2'd0:    cur_byte = hex_ascii(msg_lat[7:4]);
      2'd1:    cur_byte = hex_ascii(msg_lat[3:0]);
      2'd2:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  assign bit_end = (clk_cnt == CPB_M1);
  assign nxt_bit = bit_idx + 3'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= GAP;
      uart_txd <= 1'b1;
      q        <= 1'b0;
      msg_cnt  <= 8'h00;
      msg_lat  <= 8'h00;
      gap_cnt  <= 24'd0;
      clk_cnt  <= 16'd0;
      bit_idx  <= 3'd0;
      byte_idx <= 2'd0;
    end else begin
      case (state)
        GAP: begin
          if (gap_cnt == GAP_M1) begin
            gap_cnt  <= 24'd0;
            clk_cnt  <= 16'd0;
            byte_idx <= 2'd0;
            msg_lat  <= msg_cnt;
            q        <= ~q;
            uart_txd <= 1'b0;
            state    <= START;
          end else begin
            gap_cnt  <= gap_cnt + 24'd1;
            uart_txd <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt  <= 16'd0;
            bit_idx  <= 3'd0;
            uart_txd <= cur_byte[0];
            state    <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              uart_txd <= 1'b1;
              state    <= STOP;
            end else begin
              bit_idx  <= nxt_bit;
              uart_txd <= cur_byte[nxt_bit];
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt <= 16'd0;
            if (byte_idx == 2'd3) begin
              msg_cnt <= msg_cnt + 8'd1;
              gap_cnt <= 24'd0;
              state   <= GAP;
            end else begin
              // Next start bit follows the stop bit with no idle cycle.
              byte_idx <= byte_idx + 2'd1;
              uart_txd <= 1'b0;
              state    <= START;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        default: begin
          uart_txd <= 1'b1;
          state    <= GAP;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_servive.sv
`default_nettype none
// Directed bench: default-parameter instance plus a fast (4 clk/bit, gap 2) instance.
module tb_servive;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic q_a;
  logic txd_a;
  logic q_b;
  logic txd_b;

  int total;
  int bad;
  int cyc;

  servive dut_a (
    .i_clk    (clk),
    .i_rst    (rst_a),
    .q        (q_a),
    .uart_txd (txd_a)
  );

  servive #(
    .CLKS_PER_BIT (4),
    .MSG_GAP      (2)
  ) dut_b (
    .i_clk    (clk),
    .i_rst    (rst_b),
    .q        (q_b),
    .uart_txd (txd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic txd_of(input int which);
    return (which != 0) ? txd_b : txd_a;
  endfunction

  // Entered just after the edge that drives a start bit; leaves just after
  // the edge that ends the stop bit.
  task automatic recv(input int which, input int cpb, output logic [7:0] data, output logic good);
    logic [9:0] fr;
    good = 1'b1;
    for (int b = 0; b < 10; b++) begin
      fr[b] = txd_of(which);
      for (int c = 0; c < cpb; c++) begin
        if (txd_of(which) !== fr[b]) good = 1'b0;
        tick();
      end
    end
    if (fr[0] !== 1'b0 || fr[9] !== 1'b1) good = 1'b0;
    data = fr[8:1];
  endtask

  task automatic recv_msg(input int which, input int cpb, input string name,
                          input logic [7:0] hi, input logic [7:0] lo);
    logic [7:0] exp [4];
    logic [7:0] data;
    logic       good;
    exp[0] = hi;
    exp[1] = lo;
    exp[2] = 8'h0D;
    exp[3] = 8'h0A;
    for (int i = 0; i < 4; i++) begin
      recv(which, cpb, data, good);
      check($sformatf("%s byte%0d value", name, i), {24'd0, data}, {24'd0, exp[i]});
      check($sformatf("%s byte%0d framing", name, i), {31'd0, good}, 32'd1);
      if (i < 3)
        check($sformatf("%s byte%0d next start immediate", name, i), {31'd0, txd_of(which)}, 32'd0);
    end
    check($sformatf("%s idle after msg", name), {31'd0, txd_of(which)}, 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst txd_a", {31'd0, txd_a}, 32'd1);
      check("rst q_a",   {31'd0, q_a},   32'd0);
      check("rst txd_b", {31'd0, txd_b}, 32'd1);
      check("rst q_b",   {31'd0, q_b},   32'd0);
    end

    rst_a = 1'b0;
    rst_b = 1'b0;
    cyc   = 0;

    // Default instance: first and second messages.
    wait_until(999);
    check("a txd before first start", {31'd0, txd_a}, 32'd1);
    check("a q before first start",   {31'd0, q_a},   32'd0);
    tick();
    check("a txd first start", {31'd0, txd_a}, 32'd0);
    check("a q first start",   {31'd0, q_a},   32'd1);
    recv_msg(0, 434, "a_msg1", 8'h30, 8'h30);

    wait_until(19359);
    check("a txd before msg2", {31'd0, txd_a}, 32'd1);
    check("a q before msg2",   {31'd0, q_a},   32'd1);
    tick();
    check("a txd msg2 start", {31'd0, txd_a}, 32'd0);
    check("a q msg2 start",   {31'd0, q_a},   32'd0);
    recv_msg(0, 434, "a_msg2", 8'h30, 8'h31);

    // Fast instance: message n starts at edge 2 + (n-1)*162.
    wait_until(41311);
    check("b txd before msg256", {31'd0, txd_b}, 32'd1);
    check("b q before msg256",   {31'd0, q_b},   32'd1);
    tick();
    check("b txd msg256 start", {31'd0, txd_b}, 32'd0);
    check("b q msg256 start",   {31'd0, q_b},   32'd0);
    recv_msg(1, 4, "b_msg256", 8'h46, 8'h46);

    wait_until(41473);
    check("b txd before msg257", {31'd0, txd_b}, 32'd1);
    tick();
    check("b txd msg257 start", {31'd0, txd_b}, 32'd0);
    check("b q msg257 start",   {31'd0, q_b},   32'd1);
    recv_msg(1, 4, "b_msg257", 8'h30, 8'h30);

    // Message 259 ("02") starts at 41798; edge 41850 is bit 2 of '2' (a 0).
    wait_until(41849);
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("b mid-msg rst txd cyc%0d", i), {31'd0, txd_b}, 32'd1);
      check($sformatf("b mid-msg rst q cyc%0d", i),   {31'd0, q_b},   32'd0);
    end
    rst_b = 1'b0;
    cyc   = 0;
    tick();
    check("b txd after rst edge1", {31'd0, txd_b}, 32'd1);
    check("b q after rst edge1",   {31'd0, q_b},   32'd0);
    tick();
    check("b txd after rst start", {31'd0, txd_b}, 32'd0);
    check("b q after rst start",   {31'd0, q_b},   32'd1);
    recv_msg(1, 4, "b_after_rst", 8'h30, 8'h30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
